// File: rtl/la_pkg.sv
// Shared types and helpers for the la_capture_core logic-analyzer engine.
package la_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_WAIT = 2'd2,
        ST_POST = 2'd3
    } la_state_t;

    // Widest trigger bus la_match accepts; narrower buses are zero-extended by the caller.
    localparam int unsigned LA_TRIG_MAX = 32;

    function automatic logic la_match(
        input logic [LA_TRIG_MAX-1:0] trig,
        input logic [LA_TRIG_MAX-1:0] mask,
        input logic [LA_TRIG_MAX-1:0] val
    );
        return ((trig ^ val) & mask) == '0;
    endfunction

endpackage

// File: rtl/la_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read (BSRAM style).
module la_capture_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array itself stays reset-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: masked level/edge trigger, pre-trigger window,
// circular sample buffer and a parallel read port.
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int TRIG_W = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic              trig_edge_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_pos_o,
    output logic [AW-1:0]     start_addr_o
);

    la_state_t         state_q;
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     post_q;
    logic [TRIG_W-1:0] mask_q;
    logic [TRIG_W-1:0] val_q;
    logic              edge_q;
    logic [AW-1:0]     pre_q;
    logic              match_q;
    logic              done_q;
    logic [AW-1:0]     trig_pos_q;
    logic [AW-1:0]     start_q;
    logic              rd_valid_q;

    logic              match;
    logic              hit;
    logic              we;
    logic [AW-1:0]     wptr_d;
    logic [AW-1:0]     start_d;
    logic [AW-1:0]     post_load_d;

    // pretrig_i is AW bits wide, so it can never exceed DEPTH-1: the clamp is implicit.
    always_comb begin
        match       = la_match(LA_TRIG_MAX'(trig_i), LA_TRIG_MAX'(mask_q), LA_TRIG_MAX'(val_q));
        hit         = match & (~edge_q | ~match_q);
        we          = (state_q != ST_IDLE);
        wptr_d      = wptr_q + AW'(1);
        start_d     = wptr_q - pre_q;
        post_load_d = AW'(DEPTH - 1) - pre_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            cnt_q      <= '0;
            post_q     <= '0;
            mask_q     <= '0;
            val_q      <= '0;
            edge_q     <= 1'b0;
            pre_q      <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            trig_pos_q <= '0;
            start_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            match_q    <= match;
            rd_valid_q <= rd_en_i;
            if (abort_i) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm_i) begin
                            mask_q  <= trig_mask_i;
                            val_q   <= trig_val_i;
                            edge_q  <= trig_edge_i;
                            pre_q   <= pretrig_i;
                            wptr_q  <= '0;
                            cnt_q   <= '0;
                            done_q  <= 1'b0;
                            state_q <= (pretrig_i != '0) ? ST_PRE : ST_WAIT;
                        end
                    end
                    ST_PRE: begin
                        wptr_q <= wptr_d;
                        cnt_q  <= cnt_q + AW'(1);
                        if (cnt_q == pre_q - AW'(1)) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        wptr_q <= wptr_d;
                        if (hit) begin
                            trig_pos_q <= wptr_q;
                            start_q    <= start_d;
                            post_q     <= post_load_d;
                            if (post_load_d == '0) begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        wptr_q <= wptr_d;
                        post_q <= post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    la_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (data_i),
        .re_i    (rd_en_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o   = rd_valid_q;
    assign state_o      = state_q;
    assign done_o       = done_q;
    assign trig_pos_o   = trig_pos_q;
    assign start_addr_o = start_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed self-checking bench for la_capture_core (DEPTH=16, DATA_W=8, TRIG_W=4).
module tb_la_capture_core;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TW  = 4;
    localparam int AWL = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           arm_i;
    logic           abort_i;
    logic [DW-1:0]  data_i;
    logic [TW-1:0]  trig_i;
    logic [TW-1:0]  trig_mask_i;
    logic [TW-1:0]  trig_val_i;
    logic           trig_edge_i;
    logic [AWL-1:0] pretrig_i;
    logic           rd_en_i;
    logic [AWL-1:0] rd_addr_i;
    logic [DW-1:0]  rd_data_o;
    logic           rd_valid_o;
    logic [1:0]     state_o;
    logic           done_o;
    logic [AWL-1:0] trig_pos_o;
    logic [AWL-1:0] start_addr_o;

    int passes = 0;
    int total  = 0;
    int s      = 0;

    la_capture_core #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .TRIG_W (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .data_i       (data_i),
        .trig_i       (trig_i),
        .trig_mask_i  (trig_mask_i),
        .trig_val_i   (trig_val_i),
        .trig_edge_i  (trig_edge_i),
        .pretrig_i    (pretrig_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .state_o      (state_o),
        .done_o       (done_o),
        .trig_pos_o   (trig_pos_o),
        .start_addr_o (start_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One written sample: sample s is committed at this edge, then data_i moves on.
    task automatic advance();
        step();
        s++;
        data_i = 8'(s);
    endtask

    task automatic arm(input logic [3:0] m, input logic [3:0] v, input logic e, input logic [3:0] p);
        trig_mask_i = m;
        trig_val_i  = v;
        trig_edge_i = e;
        pretrig_i   = p;
        arm_i       = 1'b1;
        step();
        arm_i  = 1'b0;
        s      = 0;
        data_i = 8'd0;
    endtask

    task automatic run_level(input string tag);
        trig_i = 4'b0000;
        arm(4'b0001, 4'b0001, 1'b0, 4'd4);
        chk({tag, "_state_pre"}, 32'(state_o), 1);
        chk({tag, "_done_clr"}, 32'(done_o), 0);
        repeat (20) advance();
        chk({tag, "_state_wait"}, 32'(state_o), 2);
        trig_i = 4'b0001;
        advance();
        trig_i = 4'b0000;
        chk({tag, "_trig_pos"}, 32'(trig_pos_o), 4);
        chk({tag, "_start"}, 32'(start_addr_o), 0);
        chk({tag, "_state_post"}, 32'(state_o), 3);
        repeat (10) advance();
        chk({tag, "_done_early"}, 32'(done_o), 0);
        advance();
        chk({tag, "_done"}, 32'(done_o), 1);
        chk({tag, "_state_idle"}, 32'(state_o), 0);
        for (int i = 0; i < 16; i++) begin
            rd_en_i   = 1'b1;
            rd_addr_i = 4'(i);
            step();
            chk({tag, "_rd_valid"}, 32'(rd_valid_o), 1);
            chk({tag, "_rd_data"}, 32'(rd_data_o), 32'(16 + i));
        end
        rd_en_i = 1'b0;
        step();
        chk({tag, "_rd_valid_pulse"}, 32'(rd_valid_o), 0);
        chk({tag, "_rd_hold"}, 32'(rd_data_o), 31);
    endtask

    task automatic rd_one(input string tag, input logic [3:0] a, input int exp);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        step();
        rd_en_i = 1'b0;
        chk(tag, 32'(rd_data_o), 32'(exp));
    endtask

    initial begin
        rst_i       = 1'b1;
        arm_i       = 1'b0;
        abort_i     = 1'b0;
        data_i      = '0;
        trig_i      = '0;
        trig_mask_i = '0;
        trig_val_i  = '0;
        trig_edge_i = 1'b0;
        pretrig_i   = '0;
        rd_en_i     = 1'b0;
        rd_addr_i   = '0;
        step();
        step();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_trig_pos", 32'(trig_pos_o), 0);
        chk("rst_start", 32'(start_addr_o), 0);
        chk("rst_rd_valid", 32'(rd_valid_o), 0);
        chk("rst_rd_data", 32'(rd_data_o), 0);
        rst_i = 1'b0;
        step();

        // Level trigger
        run_level("lvl");

        // Edge trigger: match already true before arm, falls at 30, rises at 33
        trig_i = 4'b0001;
        step();
        arm(4'b0001, 4'b0001, 1'b1, 4'd4);
        while (s < 33) begin
            trig_i = (s >= 30) ? 4'b0000 : 4'b0001;
            advance();
        end
        chk("edge_no_early", 32'(state_o), 2);
        trig_i = 4'b0001;
        advance();
        chk("edge_trig_pos", 32'(trig_pos_o), 1);
        chk("edge_start", 32'(start_addr_o), 13);
        chk("edge_state_post", 32'(state_o), 3);
        repeat (11) advance();
        chk("edge_done", 32'(done_o), 1);
        rd_one("edge_rd_trig", 4'd1, 33);

        // Mask zero, no pre-trigger
        trig_i = 4'b0000;
        arm(4'b0000, 4'b0000, 1'b0, 4'd0);
        chk("mz_state_wait", 32'(state_o), 2);
        advance();
        chk("mz_trig_pos", 32'(trig_pos_o), 0);
        chk("mz_start", 32'(start_addr_o), 0);
        chk("mz_state_post", 32'(state_o), 3);
        repeat (14) advance();
        chk("mz_done_early", 32'(done_o), 0);
        advance();
        chk("mz_done", 32'(done_o), 1);
        rd_one("mz_rd", 4'd9, 9);

        // Pre-trigger at the maximum: zero post count
        arm(4'b0001, 4'b0001, 1'b0, 4'd15);
        chk("clamp_state_pre", 32'(state_o), 1);
        repeat (18) advance();
        trig_i = 4'b0001;
        advance();
        trig_i = 4'b0000;
        chk("clamp_done", 32'(done_o), 1);
        chk("clamp_state", 32'(state_o), 0);
        chk("clamp_trig_pos", 32'(trig_pos_o), 2);
        chk("clamp_start", 32'(start_addr_o), 3);
        rd_one("clamp_rd_oldest", 4'd3, 3);
        rd_one("clamp_rd_trig", 4'd2, 18);

        // Trigger asserted only during PRE is ignored
        arm(4'b0001, 4'b0001, 1'b0, 4'd4);
        repeat (20) begin
            trig_i = (s == 2 || s == 3) ? 4'b0001 : 4'b0000;
            advance();
        end
        chk("pre_ign_state", 32'(state_o), 2);
        chk("pre_ign_done", 32'(done_o), 0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("pre_ign_abort", 32'(state_o), 0);

        // Abort during POST with a simultaneous arm, then re-arm
        arm(4'b0001, 4'b0001, 1'b0, 4'd4);
        repeat (20) advance();
        trig_i = 4'b0001;
        advance();
        trig_i = 4'b0000;
        repeat (3) advance();
        chk("ab_state_post", 32'(state_o), 3);
        abort_i = 1'b1;
        arm_i   = 1'b1;
        step();
        abort_i = 1'b0;
        arm_i   = 1'b0;
        chk("ab_state_idle", 32'(state_o), 0);
        chk("ab_done", 32'(done_o), 0);
        step();
        chk("ab_arm_ignored", 32'(state_o), 0);
        run_level("rearm");

        // Reset mid-capture takes effect asynchronously
        arm(4'b0001, 4'b0001, 1'b0, 4'd4);
        repeat (6) advance();
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_done", 32'(done_o), 0);
        step();
        rst_i = 1'b0;
        step();
        chk("midrst_stay_idle", 32'(state_o), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised in-fabric logic-analyzer capture engine. It is the successor to the fixed 31-bit, single-trigger GAO probe we use for bring-up of the FFT/ADC path (`fft_inst`, `sum`, `xk_re_o`). Compared with that probe it adds:
- generic data width and depth;
- a multi-bit masked trigger with level or edge mode;
- a programmable pre-trigger window;
- a parallel read port, so captures can be dumped over our own host link instead of JTAG.

## Interface
Parameters:
- `DATA_W`, 32: probe data width.
- `DEPTH`, 1024: sample buffer depth. Must be a power of two, at least 4.
- `TRIG_W`, 4: trigger input width.
- `AW`, `$clog2(DEPTH)`: derived address width. Do not override.

Ports:
- `clk_i`  in  1  sample clock. One clock domain only.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `arm_i`  in  1  start a capture. Single-cycle pulse.
- `abort_i`  in  1  cancel the capture and return to IDLE.
- `data_i`  in  `DATA_W`  probe data, sampled every cycle.
- `trig_i`  in  `TRIG_W`  trigger inputs.
- `trig_mask_i`  in  `TRIG_W`  1 = bit participates in the match.
- `trig_val_i`  in  `TRIG_W`  required value of each participating bit.
- `trig_edge_i`  in  1  0 = level mode, 1 = rising edge of the match.
- `pretrig_i`  in  `AW`  number of samples kept before the trigger sample.
- `rd_en_i`  in  1  read request.
- `rd_addr_i`  in  `AW`  physical buffer address to read.
- `rd_data_o`  out  `DATA_W`  read data.
- `rd_valid_o`  out  1  `rd_data_o` is valid this cycle.
- `state_o`  out  2  current state: 0 IDLE, 1 PRE, 2 WAIT, 3 POST.
- `done_o`  out  1  capture complete, buffer holds a full record.
- `trig_pos_o`  out  `AW`  physical address of the trigger sample.
- `start_addr_o`  out  `AW`  physical address of the oldest sample in the record.

## Operation
- **Config latch:** on an accepted `arm_i`, latch `trig_mask_i`, `trig_val_i`, `trig_edge_i` and `pretrig_i`.
  - The latched pre-trigger count P = min(`pretrig_i`, `DEPTH`-1).
  - Reset write pointer `wptr` and sample counter to 0. Clear `done_o`.
- **Match:** `match = ((trig_i ^ val) & mask) == 0`.
  - `match_d` is a register updated every cycle in every state. Reset value 0.
  - Level mode: `hit = match`. Edge mode: `hit = match & ~match_d`.
- **States:**
  - IDLE: no writes. An `arm_i` pulse goes to PRE if P > 0, otherwise to WAIT.
  - PRE: write `data_i` at `wptr` and increment `wptr`. Ignore `hit`. After P writes, go to WAIT.
  - WAIT: write every cycle; `wptr` wraps modulo `DEPTH`.
    - When `hit` is seen in the same cycle as a write, that sample is the trigger sample.
    - Set `trig_pos_o` = its address and `start_addr_o` = (`trig_pos_o` - P) mod `DEPTH`.
    - Load the post counter with `DEPTH`-1-P. If that value is 0, go to IDLE with `done_o` set; otherwise go to POST.
  - POST: write and decrement the post counter. After the last write, go to IDLE with `done_o` = 1.
- **Re-arm and abort:**
  - `arm_i` is accepted only in IDLE, whether or not `done_o` is set. It is ignored in PRE, WAIT and POST.
  - `abort_i` in any state: go to IDLE next cycle and clear `done_o`. Buffer contents are not cleared.
  - `abort_i` wins over a simultaneous `arm_i`.
- **Immediate trigger:** `mask` = 0 means the match is always true.
  - Level mode: trigger on the first WAIT cycle.
  - Edge mode: trigger only if `match_d` was 0, i.e. only when arming from reset, never again.
- **Reads:**
  - Allowed in any state and never disturb the capture.
  - Data read during PRE, WAIT or POST is stale but well-defined RAM content.
  - A complete record is `DEPTH` samples, starting at `start_addr_o` and wrapping.

## Timing
- **Reset values:** all outputs 0, state IDLE, `match_d` 0.
- **Arm:** `arm_i` at cycle 0 → state changes at cycle 1. The first sample is written at cycle 1 and is `data_i` from cycle 1.
- **Trigger:** the trigger sample is written in the same cycle `hit` is evaluated. `trig_pos_o` and `start_addr_o` update on the next edge.
- **Done:** `done_o` rises the cycle after the final write. It stays high until the next accepted arm or an abort.
- **Read:** read latency is 1 cycle. `rd_en_i` at cycle n gives `rd_valid_o` and `rd_data_o` at cycle n+1. `rd_valid_o` is a pulse, and back-to-back reads are allowed. `rd_data_o` holds its value when not reading.
- **Reset mid-capture:** state goes to IDLE immediately, no further writes, `done_o` = 0.

## Structure
- **Package `la_pkg`:**
  - state enum `la_state_t` (2-bit, encoding as in `state_o`);
  - function `la_match(trig, mask, val)`.
- **Sub-module `la_capture_ram`:** simple dual-port RAM, `DEPTH` × `DATA_W`.
  - Synchronous write port and registered read port.
  - Coded to infer Gowin BSRAM.
  - No reset on the storage array.
- **Top module:** FSM, pointers, trigger logic and output registers.

## Test plan
All scenarios use `DEPTH`=16, `DATA_W`=8, `TRIG_W`=4, with `data_i` = sample index since arm (0, 1, 2, …).
1. **Level trigger:** level mode, `mask`=0001, `val`=0001, P=4, `trig_i[0]` high at sample 20 only → `trig_pos_o`=4, `start_addr_o`=0, `done_o` 12 cycles after the trigger write; reading addresses 0..15 returns 16..31.
2. **Edge trigger:** edge mode, `trig_i[0]` high from before arm, low at sample 30, high again at 33 → trigger sample is 33, `trig_pos_o`=1.
3. **Mask zero:** `mask`=0000, P=0 → trigger at sample 0, `trig_pos_o`=0, `start_addr_o`=0, `done_o` after 16 writes.
4. **Pre-trigger clamp:** `pretrig_i`=15 with a trigger at sample 18 → post count 0, `done_o` on the next cycle, `start_addr_o`=3.
5. **Trigger during PRE:** P=4, `trig_i` asserted at samples 2..3 only → no trigger; state stays WAIT.
6. **Abort and re-arm:** `abort_i` during POST → IDLE next cycle, `done_o`=0. `arm_i` in the same cycle as `abort_i` is ignored. A later `arm_i` and scenario 1 repeat correctly.
